serial_full_adder: RTL and testbench
====================================

# serial_full_adder

Bit-serial N-bit adder built around one full-adder cell and a registered carry. It sits directly downstream of the combinational full-adder cell. It sequences the operands through that cell LSB-first, one bit per clock, and collects sum bits and final carry into output registers. It trades area for latency: one full-adder evaluation per cycle instead of a WIDTH-bit ripple chain.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range 1..32.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while the adder is in SHIFT.
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle on.
- sum  output  WIDTH  registered result a+b+cin, modulo 2^WIDTH.
- cout  output  1  registered carry-out of bit WIDTH-1.

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: runs WIDTH bit-cycles.
  - DONE: one cycle.
- IDLE:
  - If start=1 on an edge, load the A/B shift registers from a/b.
  - Load the carry flop from cin, clear the bit counter and the sum shift register, and go to SHIFT.
  - If start=0, stay in IDLE.
- SHIFT, each edge:
  - s = a_sr[0] ^ b_sr[0] ^ c.
  - c_next = majority(a_sr[0], b_sr[0], c).
  - Shift s into the MSB of the sum shift register; shift a_sr and b_sr right by one.
  - c <= c_next; count <= count+1.
- SHIFT, on the edge where count == WIDTH-1:
  - Load sum from the completed shift-register value, including this cycle's s.
  - Load cout from c_next.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- sum and cout change only on the completing edge. They hold their value otherwise, including through the next operation, until that operation completes.
- start is ignored in SHIFT and DONE. There is no queueing.
- If start is held high continuously, a new operation is accepted on the first edge in IDLE.
- Counter width is clog2(WIDTH)+1. When WIDTH=1, SHIFT lasts exactly one edge.

## Timing
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE immediately.
  - busy=0, done=0, sum=0, cout=0.
  - All shift registers, carry and counter are cleared.
- Reset mid-operation aborts the operation with no done pulse. After rst_n rises, the first edge with start=1 begins a fresh operation.
- Edge E0 accepts start. busy=1 after E0.
- Edges E1..E(WIDTH-1) shift.
- Edge E(WIDTH) performs the final shift:
  - sum and cout update.
  - busy=0, done=1.
- Edge E(WIDTH+1) returns to IDLE with done=0.
- The earliest next accept is E(WIDTH+2).
- Latency from accept to done is WIDTH edges. Throughput is one operation per WIDTH+2 cycles.
- busy and done are never high together.
- Outputs are registered. No combinational path exists from inputs to outputs.

## Test plan
- Reset check: hold rst_n=0 with toggling inputs → busy=0, done=0, sum=0, cout=0 throughout. After release with start=0 → remains idle.
- Basic add, WIDTH=8: a=8'h5A, b=8'h25, cin=0, start pulsed at E0.
  - busy high E0..E7.
  - done high after E8 only, with sum=8'h7F, cout=0.
- Overflow cases, WIDTH=8:
  - a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1.
  - a=8'h5A, b=8'hA5, cin=1 → sum=8'h00, cout=1.
  - a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Start ignored and held results:
  - Pulse start with new operands at E3 during SHIFT → result still equals the first operation.
  - sum holds the previous result until the next completing edge.
- Back-to-back: hold start=1 continuously with a=1, b=2, cin=0.
  - done pulses every 10 cycles.
  - sum=8'h03 each time.
- Reset mid-operation:
  - Drop rst_n at E4 → no done, outputs 0.
  - New operation a=8'h10, b=8'h20 afterwards → sum=8'h30, cout=0, with correct latency.
- WIDTH=1 build:
  - a=1, b=1, cin=1 → sum=1, cout=1, done after E1.

Source files
------------

// File: rtl/serial_full_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_full_adder_if
// Description : Operand/result bundle for the bit-serial adder. The
//               requester drives start/a/b/cin and reads back the
//               busy/done/sum/cout status.
// Ports       : (interface signals)
//                  start  request to begin an addition
//                  a, b   WIDTH-bit operands
//                  cin    carry-in
//                  busy   adder is shifting
//                  done   one-cycle completion pulse
//                  sum    WIDTH-bit registered result
//                  cout   registered carry-out
//               modport master : requester side
//               modport slave  : adder side
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_full_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface
`default_nettype wire

// File: rtl/serial_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_full_adder
// Description : Bit-serial WIDTH-bit adder. One full-adder cell is evaluated
//               per clock, LSB first, with a registered carry. The result is
//               loaded into the output registers on the completing edge only,
//               so sum/cout hold the previous result during an operation.
// Ports       : clk    rising-edge clock
//               rst_n  asynchronous active-low reset
//               bus    serial_full_adder_if.slave
//                        in : start, a, b, cin
//                        out: busy, done, sum, cout
// Parameters  : WIDTH  operand/sum width, 1..32 (must match bus WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_full_adder #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_full_adder_if.slave   bus
);

   // Counter is one bit wider than clog2 so WIDTH=1 still gets a 1-bit counter.
   localparam int              c_CW   = $clog2(WIDTH) + 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_SHIFT = 2'd1;
   localparam logic [1:0] c_ST_DONE  = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_sum_sr;
   logic             r_carry;
   logic [c_CW-1:0]  r_count;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic             w_s;
   logic             w_c_next;
   logic [WIDTH-1:0] w_sum_next;

   // Single full-adder cell operating on the current LSBs.
   assign w_s      = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
   assign w_c_next = (r_a_sr[0] & r_b_sr[0]) |
                     (r_a_sr[0] & r_carry)   |
                     (r_b_sr[0] & r_carry);

   // New sum bit enters at the MSB; after WIDTH shifts the first bit computed
   // has walked down to bit 0. Written as shift/OR so WIDTH=1 needs no slice.
   assign w_sum_next = (r_sum_sr >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= c_ST_IDLE;
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_sum_sr <= '0;
         r_carry  <= 1'b0;
         r_count  <= '0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (bus.start) begin
                  r_a_sr   <= bus.a;
                  r_b_sr   <= bus.b;
                  r_carry  <= bus.cin;
                  r_count  <= '0;
                  r_sum_sr <= '0;
                  r_state  <= c_ST_SHIFT;
               end
            end
            c_ST_SHIFT: begin
               r_a_sr   <= r_a_sr >> 1;
               r_b_sr   <= r_b_sr >> 1;
               r_sum_sr <= w_sum_next;
               r_carry  <= w_c_next;
               r_count  <= r_count + 1'b1;
               if (r_count == c_LAST) begin
                  r_sum   <= w_sum_next;
                  r_cout  <= w_c_next;
                  r_state <= c_ST_DONE;
               end
            end
            c_ST_DONE: begin
               r_state <= c_ST_IDLE;
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   // Status flags decode the state register directly, so they stay glitch-free
   // and have no path from the request inputs.
   assign bus.busy = (r_state == c_ST_SHIFT);
   assign bus.done = (r_state == c_ST_DONE);
   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_full_adder
// Description : Directed self-checking bench for serial_full_adder, with one
//               WIDTH=8 instance and one WIDTH=1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_full_adder;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [7:0] prev_sum  = 8'h00;
   logic       prev_cout = 1'b0;

   always #5 clk = ~clk;

   serial_full_adder_if #(.WIDTH(8)) bus8 ();
   serial_full_adder_if #(.WIDTH(1)) bus1 ();

   serial_full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
   serial_full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus8.start = 1'(i);
         bus8.a     = 8'($urandom);
         bus8.b     = 8'($urandom);
         bus8.cin   = 1'($urandom);
         bus1.start = 1'(i);
         bus1.a     = 1'($urandom);
         bus1.b     = 1'($urandom);
         bus1.cin   = 1'($urandom);
         tick();
         n_tests++;
         if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_hold8[%0d]: got busy/done/cout/sum=%h, expected 0", i,
                     {bus8.busy, bus8.done, bus8.cout, bus8.sum});
         end
         n_tests++;
         if ({bus1.busy, bus1.done, bus1.cout, bus1.sum} !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_hold1[%0d]: got %h, expected 0", i,
                     {bus1.busy, bus1.done, bus1.cout, bus1.sum});
         end
      end
      bus8.start = 1'b0;
      bus1.start = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_idle[%0d]: got %h, expected 0", i,
                     {bus8.busy, bus8.done, bus8.cout, bus8.sum});
         end
      end
   endtask

   // Basic add plus the overflow corners, checking full cycle timing.
   task automatic test_add_vectors();
      logic [7:0] va   [4] = '{8'h5A, 8'hFF, 8'h5A, 8'hFF};
      logic [7:0] vb   [4] = '{8'h25, 8'h01, 8'hA5, 8'hFF};
      logic       vc   [4] = '{1'b0,  1'b0,  1'b1,  1'b1};
      logic [7:0] es   [4] = '{8'h7F, 8'h00, 8'h00, 8'hFF};
      logic       ec   [4] = '{1'b0,  1'b1,  1'b1,  1'b1};
      for (int v = 0; v < 4; v++) begin
         bus8.a = va[v]; bus8.b = vb[v]; bus8.cin = vc[v]; bus8.start = 1'b1;
         tick();                                   // E0
         bus8.start = 1'b0;
         bus8.a = ~va[v]; bus8.b = ~vb[v]; bus8.cin = ~vc[v];
         for (int k = 0; k < 8; k++) begin          // after E0..E7
            if (k != 0) tick();
            n_tests++;
            if ({bus8.busy, bus8.done} !== 2'b10) begin
               n_fail++;
               $display("FAIL add_busy[%0d] E%0d: got busy/done=%b, expected 10", v, k,
                        {bus8.busy, bus8.done});
            end
            n_tests++;
            if ({bus8.cout, bus8.sum} !== {prev_cout, prev_sum}) begin
               n_fail++;
               $display("FAIL add_hold[%0d] E%0d: got %h, expected %h", v, k,
                        {bus8.cout, bus8.sum}, {prev_cout, prev_sum});
            end
         end
         tick();                                   // E8
         n_tests++;
         if ({bus8.busy, bus8.done} !== 2'b01) begin
            n_fail++;
            $display("FAIL add_done[%0d]: got busy/done=%b, expected 01", v, {bus8.busy, bus8.done});
         end
         n_tests++;
         if (bus8.sum !== es[v] || bus8.cout !== ec[v]) begin
            n_fail++;
            $display("FAIL add_result[%0d]: got sum=%h cout=%b, expected sum=%h cout=%b",
                     v, bus8.sum, bus8.cout, es[v], ec[v]);
         end
         tick();                                   // E9
         n_tests++;
         if ({bus8.busy, bus8.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL add_idle[%0d]: got busy/done=%b, expected 00", v, {bus8.busy, bus8.done});
         end
         prev_sum = es[v]; prev_cout = ec[v];
      end
   endtask

   task automatic test_start_ignored();
      bus8.a = 8'h11; bus8.b = 8'h22; bus8.cin = 1'b0; bus8.start = 1'b1;
      tick();                                      // E0
      bus8.start = 1'b0;
      tick(); tick();                              // E1, E2
      bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b1; bus8.start = 1'b1;
      tick();                                      // E3
      bus8.start = 1'b0;
      for (int k = 4; k < 8; k++) begin
         tick();
         n_tests++;
         if (bus8.sum !== prev_sum || bus8.cout !== prev_cout) begin
            n_fail++;
            $display("FAIL ign_hold E%0d: got sum=%h cout=%b, expected sum=%h cout=%b",
                     k, bus8.sum, bus8.cout, prev_sum, prev_cout);
         end
      end
      tick();                                      // E8
      n_tests++;
      if (bus8.done !== 1'b1 || bus8.sum !== 8'h33 || bus8.cout !== 1'b0) begin
         n_fail++;
         $display("FAIL ign_result: got done=%b sum=%h cout=%b, expected done=1 sum=33 cout=0",
                  bus8.done, bus8.sum, bus8.cout);
      end
      tick(); tick();                              // E9, E10
      n_tests++;
      if ({bus8.busy, bus8.done} !== 2'b00) begin
         n_fail++;
         $display("FAIL ign_noqueue: got busy/done=%b, expected 00", {bus8.busy, bus8.done});
      end
      prev_sum = 8'h33; prev_cout = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_bd;
      bus8.a = 8'h01; bus8.b = 8'h02; bus8.cin = 1'b0; bus8.start = 1'b1;
      for (int k = 0; k < 30; k++) begin
         tick();                                   // after E(k)
         if (k == 29) bus8.start = 1'b0;
         exp_bd = ((k % 10) <= 7) ? 2'b10 : ((k % 10) == 8) ? 2'b01 : 2'b00;
         n_tests++;
         if ({bus8.busy, bus8.done} !== exp_bd) begin
            n_fail++;
            $display("FAIL b2b_flags E%0d: got busy/done=%b, expected %b", k,
                     {bus8.busy, bus8.done}, exp_bd);
         end
         if ((k % 10) == 8) begin
            n_tests++;
            if (bus8.sum !== 8'h03 || bus8.cout !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_result E%0d: got sum=%h cout=%b, expected sum=03 cout=0",
                        k, bus8.sum, bus8.cout);
            end
         end
      end
      tick();
      n_tests++;
      if (bus8.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_stop: got busy=%b, expected 0", bus8.busy);
      end
      prev_sum = 8'h03; prev_cout = 1'b0;
   endtask

   task automatic test_reset_mid();
      bus8.a = 8'h77; bus8.b = 8'h11; bus8.cin = 1'b1; bus8.start = 1'b1;
      tick();                                      // E0
      bus8.start = 1'b0;
      for (int k = 1; k <= 4; k++) tick();         // E1..E4
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'h0) begin
         n_fail++;
         $display("FAIL mid_async: got %h, expected 0", {bus8.busy, bus8.done, bus8.cout, bus8.sum});
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         if (k == 2) rst_n = 1'b1;
         n_tests++;
         if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'h0) begin
            n_fail++;
            $display("FAIL mid_nodone[%0d]: got %h, expected 0", k,
                     {bus8.busy, bus8.done, bus8.cout, bus8.sum});
         end
      end
      bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0; bus8.start = 1'b1;
      tick();                                      // E0
      bus8.start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k != 0) tick();
         n_tests++;
         if ({bus8.busy, bus8.done, bus8.sum} !== {2'b10, 8'h00}) begin
            n_fail++;
            $display("FAIL mid_rerun E%0d: got busy/done/sum=%h, expected 200", k,
                     {bus8.busy, bus8.done, bus8.sum});
         end
      end
      tick();                                      // E8
      n_tests++;
      if (bus8.done !== 1'b1 || bus8.sum !== 8'h30 || bus8.cout !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_result: got done=%b sum=%h cout=%b, expected done=1 sum=30 cout=0",
                  bus8.done, bus8.sum, bus8.cout);
      end
      tick();
   endtask

   task automatic test_width1();
      logic va [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic vb [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic vc [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic es [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic ec [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int v = 0; v < 4; v++) begin
         bus1.a = va[v]; bus1.b = vb[v]; bus1.cin = vc[v]; bus1.start = 1'b1;
         tick();                                   // E0
         bus1.start = 1'b0;
         n_tests++;
         if ({bus1.busy, bus1.done} !== 2'b10) begin
            n_fail++;
            $display("FAIL w1_busy[%0d]: got busy/done=%b, expected 10", v, {bus1.busy, bus1.done});
         end
         tick();                                   // E1
         n_tests++;
         if ({bus1.busy, bus1.done, bus1.cout, bus1.sum} !== {2'b01, ec[v], es[v]}) begin
            n_fail++;
            $display("FAIL w1_result[%0d]: got busy/done/cout/sum=%b, expected %b", v,
                     {bus1.busy, bus1.done, bus1.cout, bus1.sum}, {2'b01, ec[v], es[v]});
         end
         tick();                                   // E2
         n_tests++;
         if ({bus1.busy, bus1.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL w1_idle[%0d]: got busy/done=%b, expected 00", v, {bus1.busy, bus1.done});
         end
      end
   endtask

   initial begin
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
      test_reset();
      test_add_vectors();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      test_width1();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
